// File: rtl/mm_sched.sv
// mm_sched: sequencer for an N x N signed matrix multiply on LANES parallel MAC
// lanes that share one B operand. Issues A/B reads, drives MAC enables,
// captures each pass's lane results and serialises them into the C RAM.
module mm_sched #(
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 19,
  parameter int unsigned CW    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LANES*DW-1:0]   mac_out,
  output logic                  rd_en,
  output logic [AW-1:0]         a_addr,
  output logic [AW-1:0]         b_addr,
  output logic                  mac_en,
  output logic                  mac_first,
  output logic                  c_wr,
  output logic [AW-1:0]         c_addr,
  output logic [DW-1:0]         c_data,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         clk_count
);

  localparam int unsigned GROUPS = N / LANES;
  localparam int unsigned PASSES = N * N / LANES;
  localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;

  if (LANES > N || (N % LANES) != 0) begin : g_cfg_check
    $error("mm_sched: LANES must divide N and must not exceed N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [KW-1:0]     beat;
  logic [PW-1:0]     pass;
  logic              beat_last, pass_last;
  int unsigned       col, grp;
  logic [AW-1:0]     a_calc, b_calc, wb_calc;
  logic              last_d1, last_d2, fin_d1, fin_d2;
  logic [AW-1:0]     base_d1, base_d2;
  logic [AW-1:0]     wr_base;
  logic              wr_active, wr_final, wr_end;
  logic [LW-1:0]     wr_lane;
  logic [DW-1:0]     cap_buf [LANES];

  // Decode pass into column/row group and form the issue and write-base addresses.
  always_comb begin
    col       = 32'(pass) / GROUPS;
    grp       = 32'(pass) % GROUPS;
    a_calc    = AW'(32'(beat) * N + LANES * grp);
    b_calc    = AW'(col * N + 32'(beat));
    wb_calc   = AW'(col * N + LANES * grp);
    beat_last = (32'(beat) == N - 1);
    pass_last = (32'(pass) == PASSES - 1);
    wr_end    = wr_active && wr_final && (32'(wr_lane) == LANES - 1);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start)                  state_nx = RUN;
      RUN:   if (beat_last && pass_last) state_nx = DRAIN;
      DRAIN: if (wr_end)                 state_nx = DONE;
      DONE:  if (!start)                 state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Issue-side and status outputs decoded from state.
  always_comb begin
    rd_en  = (state == RUN);
    a_addr = '0;
    b_addr = '0;
    if (state == RUN) begin
      a_addr = a_calc;
      b_addr = b_calc;
    end
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

  // Beat and pass counters; passes run back-to-back while in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
      pass <= '0;
    end else if (state == RUN) begin
      if (beat_last) begin
        beat <= '0;
        pass <= pass_last ? '0 : pass + PW'(1);
      end else begin
        beat <= beat + KW'(1);
      end
    end else begin
      beat <= '0;
      pass <= '0;
    end
  end

  // MAC control and pass-end markers follow the RAM read latency; the write
  // base address travels with the marker so it is valid at capture time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      last_d1   <= 1'b0;
      last_d2   <= 1'b0;
      fin_d1    <= 1'b0;
      fin_d2    <= 1'b0;
      base_d1   <= '0;
      base_d2   <= '0;
    end else begin
      mac_en    <= rd_en;
      mac_first <= rd_en && (beat == '0);
      last_d1   <= rd_en && beat_last;
      fin_d1    <= rd_en && beat_last && pass_last;
      base_d1   <= wb_calc;
      last_d2   <= last_d1;
      fin_d2    <= fin_d1;
      base_d2   <= base_d1;
    end
  end

  // Capture all lane results at pass end, then step through them one per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) cap_buf[i] <= '0;
      wr_base   <= '0;
      wr_active <= 1'b0;
      wr_final  <= 1'b0;
      wr_lane   <= '0;
    end else if (last_d2) begin
      for (int unsigned i = 0; i < LANES; i++) cap_buf[i] <= mac_out[i*DW +: DW];
      wr_base   <= base_d2;
      wr_final  <= fin_d2;
      wr_active <= 1'b1;
      wr_lane   <= '0;
    end else if (wr_active) begin
      if (32'(wr_lane) == LANES - 1) begin
        wr_active <= 1'b0;
        wr_final  <= 1'b0;
        wr_lane   <= '0;
      end else begin
        wr_lane <= wr_lane + LW'(1);
      end
    end
  end

  // Output RAM write port, zero when not writing.
  always_comb begin
    c_wr   = wr_active;
    c_addr = '0;
    c_data = '0;
    if (wr_active) begin
      c_addr = wr_base + AW'(wr_lane);
      c_data = cap_buf[wr_lane];
    end
  end

  // Run-length counter: cleared on start, saturating count of busy cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            clk_count <= '0;
    else if (state == IDLE && start)       clk_count <= '0;
    else if (busy && (clk_count != '1))    clk_count <= clk_count + CW'(1);
  end

endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: drives mm_sched with behavioural A/B RAMs and MAC lanes and
// checks the write stream against C = A*B computed directly from the matrices.
module tb_mm_sched;
  localparam int N = 8, LANES = 4, AW = 6, DW = 19, CW = 11;
  localparam int TR = 200;

  logic                 clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [LANES*DW-1:0]  mac_out;
  logic                 rd_en, mac_en, mac_first, c_wr, busy, done;
  logic [AW-1:0]        a_addr, b_addr, c_addr;
  logic signed [DW-1:0] c_data;
  logic [CW-1:0]        clk_count;

  mm_sched #(.N(N), .LANES(LANES), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mac_out(mac_out),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en),
    .mac_first(mac_first), .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data),
    .busy(busy), .done(done), .clk_count(clk_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: synchronous-read A/B RAMs and signed MAC lanes.
  logic signed [7:0]    amem [N*N];
  logic signed [7:0]    bmem [N*N];
  logic signed [7:0]    a_q  [LANES];
  logic signed [7:0]    b_q;
  logic signed [DW-1:0] acc  [LANES];

  always @(posedge clk) begin
    if (rd_en) begin
      for (int l = 0; l < LANES; l++) a_q[l] <= amem[int'(a_addr) + l];
      b_q <= bmem[b_addr];
    end
  end

  always @(posedge clk) begin
    if (mac_en)
      for (int l = 0; l < LANES; l++)
        acc[l] <= mac_first ? DW'(a_q[l]) * DW'(b_q) : acc[l] + DW'(a_q[l]) * DW'(b_q);
  end

  always_comb begin
    mac_out = '0;
    for (int l = 0; l < LANES; l++) mac_out[l*DW +: DW] = acc[l];
  end

  typedef struct {int rd, a, b, me, mf, cw, ca, bsy, dn, cc;} obs_t;
  typedef struct {int off; obs_t e;} vec_t;

  obs_t tr [TR];
  vec_t tbl[$];
  int   wr_a[$];
  int   wr_d[$];
  int   s_cyc = 0;
  bit   logging = 1'b0;
  int   n_tests = 0, n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void rec();
    int o = cyc - s_cyc;
    if (o >= 0 && o < TR)
      tr[o] = '{int'(rd_en), int'(a_addr), int'(b_addr), int'(mac_en), int'(mac_first),
                int'(c_wr), int'(c_addr), int'(busy), int'(done), int'(clk_count)};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (c_wr) begin
      wr_a.push_back(int'(c_addr));
      wr_d.push_back(int'(c_data));
    end
    if (logging) rec();
  endtask

  function automatic void add(int off, int rd, int a, int b, int me, int mf,
                              int cw, int ca, int bsy, int dn, int cc);
    tbl.push_back('{off, '{rd, a, b, me, mf, cw, ca, bsy, dn, cc}});
  endfunction

  function automatic bit m(int act, int exp);
    return (exp < 0) || (act == exp);
  endfunction

  function automatic void check_table(string tag);
    foreach (tbl[v]) begin
      obs_t g = tr[tbl[v].off];
      obs_t e = tbl[v].e;
      n_tests++;
      if (!(m(g.rd, e.rd) && m(g.a, e.a) && m(g.b, e.b) && m(g.me, e.me) && m(g.mf, e.mf) &&
            m(g.cw, e.cw) && m(g.ca, e.ca) && m(g.bsy, e.bsy) && m(g.dn, e.dn) && m(g.cc, e.cc))) begin
        n_fail++;
        $display("FAIL %s cycle S+%0d: got rd=%0d a=%0d b=%0d me=%0d mf=%0d cw=%0d ca=%0d busy=%0d done=%0d cc=%0d expected rd=%0d a=%0d b=%0d me=%0d mf=%0d cw=%0d ca=%0d busy=%0d done=%0d cc=%0d (-1 = any)",
                 tag, tbl[v].off, g.rd, g.a, g.b, g.me, g.mf, g.cw, g.ca, g.bsy, g.dn, g.cc,
                 e.rd, e.a, e.b, e.me, e.mf, e.cw, e.ca, e.bsy, e.dn, e.cc);
      end
    end
  endfunction

  // Reference: C = A*B from column-major storage; writes expected in pass order.
  function automatic void check_writes(int base, string tag);
    int cm [N][N];
    int cnt = wr_a.size() - base;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cm[i][j] = 0;
        for (int k = 0; k < N; k++) cm[i][j] += int'(amem[k*N + i]) * int'(bmem[j*N + k]);
      end
    chk({tag, " write_count"}, cnt, N*N);
    for (int n = 0; n < N*N && n < cnt; n++) begin
      int p = n / LANES, l = n % LANES;
      int j = p / (N/LANES), g = p % (N/LANES);
      int i = LANES*g + l;
      chk($sformatf("%s wr%0d c_addr", tag, n), wr_a[base + n], j*N + i);
      chk($sformatf("%s wr%0d c_data", tag, n), wr_d[base + n], cm[i][j]);
    end
  endfunction

  function automatic void chk_zero(string tag);
    chk({tag, " rd_en"}, int'(rd_en), 0);
    chk({tag, " a_addr"}, int'(a_addr), 0);
    chk({tag, " b_addr"}, int'(b_addr), 0);
    chk({tag, " mac_en"}, int'(mac_en), 0);
    chk({tag, " mac_first"}, int'(mac_first), 0);
    chk({tag, " c_wr"}, int'(c_wr), 0);
    chk({tag, " c_addr"}, int'(c_addr), 0);
    chk({tag, " c_data"}, int'(c_data), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " clk_count"}, int'(clk_count), 0);
  endfunction

  // One run: start sampled in cycle S; optional extra start pulse; optional hold.
  task automatic run_once(input int pulse_at, input bit hold, string tag, output int base);
    int done_t = -1;
    tick();
    s_cyc = cyc; logging = 1'b1; rec();
    start = 1'b1;
    base = wr_a.size();
    for (int t = 1; t <= 300 && done_t < 0; t++) begin
      tick();
      if (done) done_t = t;
      start = hold ? 1'b1 : (t == pulse_at);
    end
    logging = 1'b0;
    chk({tag, " done_latency"}, done_t, 135);
    chk({tag, " clk_count"}, int'(clk_count), 134);
  endtask

  task automatic set_ident();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        amem[k*N + i] = (i == k) ? 8'sd1 : 8'sd0;
        bmem[i*N + k] = 8'(8*k + i + 1);
      end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int x = 0; x < N*N; x++) begin
      amem[x] = 8'(av);
      bmem[x] = 8'(bv);
    end
  endtask

  task automatic set_random();
    for (int x = 0; x < N*N; x++) begin
      amem[x] = 8'($urandom_range(0, 255));
      bmem[x] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    int b, n0;
    // First pass, pass boundaries and tail of the run, relative to start cycle S.
    //   off  rd  a   b  me mf cw  ca bsy dn  cc
    add(0,    0,  0,  0, 0, 0, 0, -1, 0, 0, -1);
    add(1,    1,  0,  0, 0, 0, 0, -1, 1, 0,  0);
    add(2,    1,  8,  1, 1, 1, 0, -1, 1, 0,  1);
    add(3,    1, 16,  2, 1, 0, 0, -1, 1, 0,  2);
    add(8,    1, 56,  7, 1, 0, 0, -1, 1, 0,  7);
    add(9,    1,  4,  0, 1, 0, 0, -1, 1, 0,  8);
    add(10,   1, 12,  1, 1, 1, 0, -1, 1, 0,  9);
    add(11,   1, 20,  2, 1, 0, 1,  0, 1, 0, 10);
    add(12,   1, 28,  3, 1, 0, 1,  1, 1, 0, 11);
    add(14,   1, 44,  5, 1, 0, 1,  3, 1, 0, 13);
    add(15,   1, 52,  6, 1, 0, 0, -1, 1, 0, 14);
    add(17,   1,  0,  8, 1, 0, 0, -1, 1, 0, 16);
    add(18,   1,  8,  9, 1, 1, 0, -1, 1, 0, 17);
    add(128,  1, 60, 63, 1, 0, 0, -1, 1, 0, 127);
    add(129,  0, -1, -1, 1, 0, 0, -1, 1, 0, 128);
    add(130,  0, -1, -1, 0, 0, 0, -1, 1, 0, 129);
    add(131,  0, -1, -1, 0, 0, 1, 60, 1, 0, 130);
    add(134,  0, -1, -1, 0, 0, 1, 63, 1, 0, 133);
    add(135,  0,  0,  0, 0, 0, 0, -1, 0, 1, 134);

    reset = 1'b0; start = 1'b0;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b1;
    tick(); tick();

    set_ident();
    run_once(0, 1'b0, "ident", b);
    check_writes(b, "ident");
    check_table("ident");

    set_const(-128, 127);
    run_once(0, 1'b0, "extreme", b);
    check_writes(b, "extreme");
    if (wr_a.size() > b) chk("extreme first c_data", wr_d[b], -130048);

    set_random();
    run_once(0, 1'b0, "rand0", b);
    check_writes(b, "rand0");

    set_random();
    run_once(50, 1'b0, "restart_pulse", b);
    check_writes(b, "restart_pulse");

    // Reset at S+70 aborts the run immediately.
    set_random();
    tick();
    s_cyc = cyc; start = 1'b1; b = wr_a.size();
    for (int t = 1; t <= 70; t++) begin
      tick();
      start = 1'b0;
    end
    chk("abort writes before reset", wr_a.size() - b, 32);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    n0 = wr_a.size();
    repeat (5) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("abort no further c_wr", wr_a.size(), n0);
    chk("abort idle busy", int'(busy), 0);
    chk("abort idle done", int'(done), 0);
    run_once(0, 1'b0, "after_abort", b);
    check_writes(b, "after_abort");

    // start held through DONE, then 4-phase release and a second identical run.
    set_random();
    run_once(0, 1'b1, "hold", b);
    check_writes(b, "hold");
    repeat (5) tick();
    chk("hold stays done", int'(done), 1);
    chk("hold not busy", int'(busy), 0);
    start = 1'b0;
    tick();
    chk("release done low", int'(done), 0);
    chk("release busy low", int'(busy), 0);
    run_once(0, 1'b0, "rerun", b);
    check_writes(b, "rerun");
    check_table("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
